// File: rtl/compa_seq_ctrl.sv
// -----------------------------------------------------------------------------
// compa_seq_ctrl
//   Laser comparator threshold sequencer. Walks a table of SEG_NUM threshold
//   codes, one entry every CYC_CNT clocks, and sends each code to the serial
//   DAC driver over a valid/ready handshake. A one-shot boot write and a host
//   override (both on channel B) are arbitrated with the segment writes.
//   Also reports the max/min of the table.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   tbl_data       new table, entry i = bits [i*DA_W +: DA_W]
//   tbl_load       one-cycle strobe, captures tbl_data
//   laser_enable   0 = segment writes carry code 0
//   ovr_code       channel-B override code
//   ovr_we         one-cycle strobe, requests an override write
//   dac_ready      driver accepts a word when dac_ready && dac_set
//   dac_value      {ch, 3'b0, code left-justified in 12 bits}
//   dac_set        word valid
//   seg_idx        index of the segment most recently requested
//   cycle_done     one-cycle pulse when seg_idx wraps to 0
//   dac_max/min    max/min table entry
//   drop_cnt       segment requests lost to overrun, saturating
//
// Arbiter states
//   state  | meaning
//   S_IDLE | no word in flight; grant boot > ovr > seg
//   S_SEND | dac_value/dac_set held until dac_ready
//   S_GAP  | one dead cycle after a transfer
// -----------------------------------------------------------------------------
module compa_seq_ctrl #(
    parameter int SEG_NUM   = 9,
    parameter int DA_W      = 10,
    parameter int CODE_W    = 8,
    parameter int CYC_CNT   = 813,
    parameter int BOOT_DLY  = 870,
    parameter int BOOT_CODE = 155,
    parameter logic [SEG_NUM*DA_W-1:0] INIT_TABLE =
        {10'd123, 10'd143, 10'd162, 10'd181, 10'd200,
         10'd191, 10'd172, 10'd152, 10'd133}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEG_NUM*DA_W-1:0]  tbl_data,
    input  logic                     tbl_load,
    input  logic                     laser_enable,
    input  logic [CODE_W-1:0]        ovr_code,
    input  logic                     ovr_we,
    input  logic                     dac_ready,
    output logic [15:0]              dac_value,
    output logic                     dac_set,
    output logic [4:0]               seg_idx,
    output logic                     cycle_done,
    output logic [DA_W-1:0]          dac_max,
    output logic [DA_W-1:0]          dac_min,
    output logic [7:0]               drop_cnt
);

    localparam int TW = $clog2(CYC_CNT);
    localparam int BW = $clog2(BOOT_DLY + 1);
    localparam int SW = $clog2(SEG_NUM + 1);

    function automatic logic [DA_W-1:0] tbl_ext(input logic [SEG_NUM*DA_W-1:0] t,
                                                input logic want_max);
        logic [DA_W-1:0] r;
        r = t[DA_W-1:0];
        for (int i = 1; i < SEG_NUM; i++) begin
            if (want_max ? (t[i*DA_W +: DA_W] > r) : (t[i*DA_W +: DA_W] < r))
                r = t[i*DA_W +: DA_W];
        end
        return r;
    endfunction

    function automatic logic [11:0] justify(input logic [CODE_W-1:0] c);
        logic [11:0] r;
        r = '0;
        r[11 -: CODE_W] = c;
        return r;
    endfunction

    localparam logic [DA_W-1:0] INIT_MAX = tbl_ext(INIT_TABLE, 1'b1);
    localparam logic [DA_W-1:0] INIT_MIN = tbl_ext(INIT_TABLE, 1'b0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                    state;
    logic [SEG_NUM*DA_W-1:0]   tbl;
    logic [TW-1:0]             tmr;
    logic [BW-1:0]             boot_cnt;
    logic                      boot_done, boot_pend;
    logic                      ovr_pend, seg_pend;
    logic [CODE_W-1:0]         ovr_lat, seg_code;
    logic                      scan_busy;
    logic [SW-1:0]             scan_i;
    logic [DA_W-1:0]           run_max, run_min;

    logic                      tick, boot_evt;
    logic                      boot_req, ovr_req, seg_req;
    logic                      grant_boot, grant_ovr, grant_seg;
    logic [4:0]                seg_nxt;
    logic [CODE_W-1:0]         tick_code, ovr_word, seg_word;
    logic [DA_W-1:0]           scan_ent;

    assign tick      = (tmr == TW'(CYC_CNT - 1));
    assign boot_evt  = !boot_done && (boot_cnt == BW'(BOOT_DLY - 1));
    assign seg_nxt   = (seg_idx == 5'(SEG_NUM - 1)) ? 5'd0 : seg_idx + 5'd1;
    assign tick_code = laser_enable ? tbl[seg_nxt*DA_W +: CODE_W] : '0;
    assign scan_ent  = tbl[scan_i*DA_W +: DA_W];

    // Fresh events bypass their pend flag so an idle arbiter answers a tick
    // in one clock; an already-pending request always goes out first.
    assign boot_req   = boot_pend | boot_evt;
    assign ovr_req    = ovr_pend | ovr_we;
    assign seg_req    = seg_pend | tick;
    assign grant_boot = (state == S_IDLE) && boot_req;
    assign grant_ovr  = (state == S_IDLE) && !boot_req && ovr_req;
    assign grant_seg  = (state == S_IDLE) && !boot_req && !ovr_req && seg_req;
    assign ovr_word   = ovr_pend ? ovr_lat : ovr_code;
    assign seg_word   = seg_pend ? seg_code : tick_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr        <= '0;
            seg_idx    <= 5'(SEG_NUM - 1);
            cycle_done <= 1'b0;
            seg_pend   <= 1'b0;
            seg_code   <= '0;
            drop_cnt   <= '0;
            boot_cnt   <= '0;
            boot_done  <= 1'b0;
            boot_pend  <= 1'b0;
            ovr_pend   <= 1'b0;
            ovr_lat    <= '0;
        end else begin
            tmr        <= tick ? '0 : tmr + TW'(1);
            cycle_done <= 1'b0;
            if (tick) begin
                seg_idx    <= seg_nxt;
                cycle_done <= (seg_nxt == 5'd0);
            end

            // Tick sent straight through leaves nothing pending; otherwise the
            // new code is latched, and overwriting an unsent code is a drop.
            if (tick && !(grant_seg && !seg_pend)) begin
                seg_pend <= 1'b1;
                seg_code <= tick_code;
                if (seg_pend && !grant_seg && drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end else if (grant_seg) begin
                seg_pend <= 1'b0;
            end

            if (ovr_we && !(grant_ovr && !ovr_pend)) begin
                ovr_pend <= 1'b1;
                ovr_lat  <= ovr_code;
            end else if (grant_ovr) begin
                ovr_pend <= 1'b0;
            end

            if (!boot_done) begin
                boot_cnt <= boot_cnt + BW'(1);
                if (boot_evt) begin
                    boot_done <= 1'b1;
                    boot_pend <= !grant_boot;
                end
            end else if (grant_boot) begin
                boot_pend <= 1'b0;
            end
        end
    end

    // Table capture and one-entry-per-clock max/min scan; results are
    // published together once the whole table has been visited.
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl       <= INIT_TABLE;
            scan_busy <= 1'b0;
            scan_i    <= '0;
            run_max   <= '0;
            run_min   <= '0;
            dac_max   <= INIT_MAX;
            dac_min   <= INIT_MIN;
        end else if (tbl_load) begin
            tbl       <= tbl_data;
            scan_busy <= 1'b1;
            scan_i    <= '0;
        end else if (scan_busy) begin
            if (scan_i == SW'(SEG_NUM)) begin
                dac_max   <= run_max;
                dac_min   <= run_min;
                scan_busy <= 1'b0;
            end else begin
                if (scan_i == '0 || scan_ent > run_max) run_max <= scan_ent;
                if (scan_i == '0 || scan_ent < run_min) run_min <= scan_ent;
                scan_i <= scan_i + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dac_value <= '0;
            dac_set   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_boot) begin
                        dac_value <= {1'b1, 3'b000, justify(CODE_W'(BOOT_CODE))};
                        dac_set   <= 1'b1;
                        state     <= S_SEND;
                    end else if (grant_ovr) begin
                        dac_value <= {1'b1, 3'b000, justify(ovr_word)};
                        dac_set   <= 1'b1;
                        state     <= S_SEND;
                    end else if (grant_seg) begin
                        dac_value <= {1'b0, 3'b000, justify(seg_word)};
                        dac_set   <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (dac_ready) begin
                        dac_set <= 1'b0;
                        state   <= S_GAP;
                    end
                end
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compa_seq_ctrl.sv
module tb_compa_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [89:0] tbl_data = '0;
    logic        tbl_load = 1'b0;
    logic        laser_enable = 1'b1;
    logic [7:0]  ovr_code = '0;
    logic        ovr_we = 1'b0;
    logic        dac_ready = 1'b1;
    logic [15:0] dac_value;
    logic        dac_set;
    logic [4:0]  seg_idx;
    logic        cycle_done;
    logic [9:0]  dac_max, dac_min;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int boot_words = 0;

    compa_seq_ctrl dut (
        .clk(clk), .rst(rst), .tbl_data(tbl_data), .tbl_load(tbl_load),
        .laser_enable(laser_enable), .ovr_code(ovr_code), .ovr_we(ovr_we),
        .dac_ready(dac_ready), .dac_value(dac_value), .dac_set(dac_set),
        .seg_idx(seg_idx), .cycle_done(cycle_done), .dac_max(dac_max),
        .dac_min(dac_min), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // cyc = number of clock edges seen since reset release
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (!rst && dac_set && dac_ready && dac_value == 16'h89B0)
            boot_words <= boot_words + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dac_value !== 16'h0000) begin n_fail++; $display("FAIL rst_value: got %h want 0000", dac_value); end
        n_checks++; if (dac_set !== 1'b0) begin n_fail++; $display("FAIL rst_set: got %b want 0", dac_set); end
        n_checks++; if (seg_idx !== 5'd8) begin n_fail++; $display("FAIL rst_idx: got %0d want 8", seg_idx); end
        n_checks++; if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL rst_cycle_done: got %b want 0", cycle_done); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
        n_checks++; if (dac_max !== 10'd200) begin n_fail++; $display("FAIL rst_max: got %0d want 200", dac_max); end
        n_checks++; if (dac_min !== 10'd123) begin n_fail++; $display("FAIL rst_min: got %0d want 123", dac_min); end
        rst = 1'b0;
    endtask

    task automatic test_segment_stream;
        goto(812);
        n_checks++; if (dac_set !== 1'b0) begin n_fail++; $display("FAIL pre_tick_set: got %b want 0", dac_set); end
        goto(813);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0850) begin n_fail++; $display("FAIL tick1_word: set %b value %h want 1 0850", dac_set, dac_value); end
        n_checks++; if (seg_idx !== 5'd0 || cycle_done !== 1'b1) begin n_fail++; $display("FAIL tick1_wrap: idx %0d done %b want 0 1", seg_idx, cycle_done); end
        goto(814);
        n_checks++; if (dac_set !== 1'b0 || cycle_done !== 1'b0) begin n_fail++; $display("FAIL tick1_accept: set %b done %b want 0 0", dac_set, cycle_done); end
        goto(869);
        n_checks++; if (dac_set !== 1'b0) begin n_fail++; $display("FAIL pre_boot_set: got %b want 0", dac_set); end
        goto(870);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h89B0) begin n_fail++; $display("FAIL boot_word: set %b value %h want 1 89B0", dac_set, dac_value); end
        goto(1626);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0980 || seg_idx !== 5'd1) begin n_fail++; $display("FAIL tick2_word: set %b value %h idx %0d want 1 0980 1", dac_set, dac_value, seg_idx); end
        n_checks++; if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL tick2_no_wrap: got %b want 0", cycle_done); end
    endtask

    task automatic test_laser_enable;
        laser_enable = 1'b0;
        goto(2439);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0000 || seg_idx !== 5'd2) begin n_fail++; $display("FAIL laser_off_word: set %b value %h idx %0d want 1 0000 2", dac_set, dac_value, seg_idx); end
        laser_enable = 1'b1;
        goto(3252);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0BF0) begin n_fail++; $display("FAIL laser_on_word: set %b value %h want 1 0BF0", dac_set, dac_value); end
    endtask

    task automatic test_drop_overrun;
        goto(3253);
        dac_ready = 1'b0;
        goto(4065);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0C80 || seg_idx !== 5'd4) begin n_fail++; $display("FAIL stall_word: set %b value %h idx %0d want 1 0C80 4", dac_set, dac_value, seg_idx); end
        goto(4878);
        n_checks++; if (dac_value !== 16'h0C80 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL stall_hold1: value %h drop %0d want 0C80 0", dac_value, drop_cnt); end
        goto(5691);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0C80 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL stall_drop: set %b value %h drop %0d want 1 0C80 1", dac_set, dac_value, drop_cnt); end
        dac_ready = 1'b1;
        goto(5692);
        n_checks++; if (dac_set !== 1'b0) begin n_fail++; $display("FAIL release_accept: got %b want 0", dac_set); end
        goto(5693);
        n_checks++; if (dac_set !== 1'b0) begin n_fail++; $display("FAIL release_gap: got %b want 0", dac_set); end
        goto(5694);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0A20) begin n_fail++; $display("FAIL release_latest: set %b value %h want 1 0A20", dac_set, dac_value); end
    endtask

    task automatic test_ovr_tick;
        goto(6503);
        ovr_code = 8'h40;
        ovr_we   = 1'b1;
        goto(6504);
        ovr_we   = 1'b0;
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h8400) begin n_fail++; $display("FAIL ovr_first: set %b value %h want 1 8400", dac_set, dac_value); end
        goto(6506);
        n_checks++; if (dac_set !== 1'b0) begin n_fail++; $display("FAIL ovr_gap: got %b want 0", dac_set); end
        goto(6507);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h08F0 || seg_idx !== 5'd7) begin n_fail++; $display("FAIL ovr_then_seg: set %b value %h idx %0d want 1 08F0 7", dac_set, dac_value, seg_idx); end
    endtask

    task automatic test_tbl_load;
        for (int i = 0; i < 9; i++) tbl_data[i*10 +: 10] = 10'(10 * (i + 1));
        tbl_load = 1'b1;
        goto(6508);
        tbl_load = 1'b0;
        goto(6517);
        n_checks++; if (dac_max !== 10'd200 || dac_min !== 10'd123) begin n_fail++; $display("FAIL scan_early: max %0d min %0d want 200 123", dac_max, dac_min); end
        goto(6518);
        n_checks++; if (dac_max !== 10'd90 || dac_min !== 10'd10) begin n_fail++; $display("FAIL scan_done: max %0d min %0d want 90 10", dac_max, dac_min); end
        goto(7317);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h05A0 || seg_idx !== 5'd8) begin n_fail++; $display("FAIL new_tbl_word: set %b value %h idx %0d want 1 05A0 8", dac_set, dac_value, seg_idx); end
        goto(8130);
        n_checks++; if (dac_value !== 16'h00A0 || cycle_done !== 1'b1 || seg_idx !== 5'd0) begin n_fail++; $display("FAIL new_tbl_wrap: value %h done %b idx %0d want 00A0 1 0", dac_value, cycle_done, seg_idx); end
    endtask

    task automatic test_tbl_reload;
        goto(8131);
        for (int i = 0; i < 9; i++) tbl_data[i*10 +: 10] = (i == 0) ? 10'd5 : 10'd700;
        tbl_load = 1'b1;
        goto(8132);
        tbl_load = 1'b0;
        goto(8135);
        for (int i = 0; i < 9; i++) tbl_data[i*10 +: 10] = (i == 4) ? 10'd3 : 10'(100 + 25 * i);
        tbl_load = 1'b1;
        goto(8136);
        tbl_load = 1'b0;
        goto(8142);
        n_checks++; if (dac_max !== 10'd90 || dac_min !== 10'd10) begin n_fail++; $display("FAIL reload_no_first: max %0d min %0d want 90 10", dac_max, dac_min); end
        goto(8145);
        n_checks++; if (dac_max !== 10'd90 || dac_min !== 10'd10) begin n_fail++; $display("FAIL reload_early: max %0d min %0d want 90 10", dac_max, dac_min); end
        goto(8146);
        n_checks++; if (dac_max !== 10'd300 || dac_min !== 10'd3) begin n_fail++; $display("FAIL reload_done: max %0d min %0d want 300 3", dac_max, dac_min); end
    endtask

    // Reset abandons a stalled word; after release a stalled first segment
    // word lets boot and the next segment both queue, and boot wins.
    task automatic test_reset_boot_priority;
        dac_ready = 1'b0;
        goto(8943);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h07D0) begin n_fail++; $display("FAIL stall_before_rst: set %b value %h want 1 07D0", dac_set, dac_value); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (dac_set !== 1'b0 || dac_value !== 16'h0000 || seg_idx !== 5'd8) begin n_fail++; $display("FAIL rst_mid_send: set %b value %h idx %0d want 0 0000 8", dac_set, dac_value, seg_idx); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        goto(813);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0850) begin n_fail++; $display("FAIL rerun_tick1: set %b value %h want 1 0850", dac_set, dac_value); end
        goto(1626);
        n_checks++; if (dac_value !== 16'h0850 || seg_idx !== 5'd1 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rerun_stall: value %h idx %0d drop %0d want 0850 1 0", dac_value, seg_idx, drop_cnt); end
        dac_ready = 1'b1;
        goto(1628);
        n_checks++; if (dac_set !== 1'b0) begin n_fail++; $display("FAIL rerun_gap: got %b want 0", dac_set); end
        goto(1629);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h89B0) begin n_fail++; $display("FAIL boot_priority: set %b value %h want 1 89B0", dac_set, dac_value); end
        goto(1632);
        n_checks++; if (dac_set !== 1'b1 || dac_value !== 16'h0980) begin n_fail++; $display("FAIL seg_after_boot: set %b value %h want 1 0980", dac_set, dac_value); end
        goto(1700);
        // one boot word per reset, so exactly two across the whole run
        n_checks++; if (boot_words !== 2) begin n_fail++; $display("FAIL boot_once: got %0d boot words want 2", boot_words); end
    endtask

    initial begin
        test_reset;
        test_segment_stream;
        test_laser_enable;
        test_drop_overrun;
        test_ovr_tick;
        test_tbl_load;
        test_tbl_reload;
        test_reset_boot_priority;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
